fetch_prefetch: RTL and testbench

Parametrised instruction-fetch stage with a prefetch queue: issues sequential reads to the single-port instruction memory, buffers returned words with their PC, and presents them downstream over a valid/ready handshake. It sits between the step/tick generator and `decode`, replacing the unbuffered fetch path. It adds redirect (branch) flushing with in-flight cancellation, issue gating by an external step enable, and back-pressure.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 54 +++++
 rtl/fetch_prefetch.sv | 94 +++++++++
 tb/tb_fetch_prefetch.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the prefetching instruction-fetch stage.
package fetch_pkg;

  localparam int FETCH_XLEN = 32;
  localparam logic [FETCH_XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int PC_STEP_DEFAULT = 4;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch queue: write lands at end of push cycle, head is visible next cycle.
// No internal backpressure; the fetch credit check keeps pushes away from a full queue.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type dat_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  dat_t                   i_push_dat,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output dat_t                   o_head_dat,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  dat_t          r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: the pointers alone define which slots are live.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  assign o_head_dat = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
  assign o_count    = r_count;

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction fetch with prefetch queue: issue at N, entry pushed end of N+1, out_valid at N+2.
// Issue stalls when step_en is low or queue+inflight reaches DEPTH; redirect flushes and kills.
module fetch_prefetch
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter int              PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   step_en,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   mem_req,
  output logic [XLEN-1:0]        mem_addr,
  input  logic [XLEN-1:0]        mem_rdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_inst,
  output logic [XLEN-1:0]        out_pc,
  output logic [$clog2(DEPTH):0] count
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } entry_t;

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_inflight_pc;
  logic            r_inflight;
  logic            r_kill;

  logic [CW:0]     w_occ;
  logic            w_push;
  logic            w_pop;
  entry_t          w_push_dat;
  entry_t          w_head;

  // Credits: a slot is reserved for the read still in flight, so a push never overflows.
  assign w_occ    = {1'b0, count} + {{CW{1'b0}}, r_inflight};
  assign mem_req  = step_en && !redirect_valid && (w_occ < (CW+1)'(DEPTH));
  assign mem_addr = r_pc;

  assign out_valid = (count != '0) && !redirect_valid;
  assign w_pop     = out_valid && out_ready;
  assign w_push    = r_inflight && !r_kill;

  assign w_push_dat.pc   = r_inflight_pc;
  assign w_push_dat.inst = mem_rdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc          <= RESET_PC;
      r_inflight_pc <= '0;
      r_inflight    <= 1'b0;
      r_kill        <= 1'b0;
    end else if (redirect_valid) begin
      // A response landing this cycle is dropped by the queue flush; mark it killed too.
      r_pc       <= redirect_pc;
      r_inflight <= 1'b0;
      r_kill     <= 1'b1;
    end else if (mem_req) begin
      r_pc          <= r_pc + XLEN'(PC_STEP);
      r_inflight    <= 1'b1;
      r_inflight_pc <= r_pc;
      r_kill        <= 1'b0;
    end else begin
      r_inflight <= 1'b0;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .dat_t (entry_t)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (w_pop),
    .i_flush    (redirect_valid),
    .o_head_dat (w_head),
    .o_count    (count)
  );

  assign out_inst = w_head.inst;
  assign out_pc   = w_head.pc;

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch: streaming, backpressure, redirect, step gating, reset, PC wrap.
module tb_fetch_prefetch;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, step_en, redirect_valid, out_ready;
  logic [XLEN-1:0] redirect_pc, mem_addr, mem_rdata, out_inst, out_pc;
  logic            mem_req, out_valid;
  logic [CW-1:0]   count;

  logic            b_rst, b_step_en, b_redirect_valid, b_out_ready;
  logic [XLEN-1:0] b_redirect_pc, b_mem_addr, b_mem_rdata, b_out_inst, b_out_pc;
  logic            b_mem_req, b_out_valid;
  logic [CW-1:0]   b_count;

  fetch_prefetch #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst), .step_en(step_en), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .count(count)
  );

  fetch_prefetch #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8), .PC_STEP(4)) dut_wrap (
    .clk(clk), .rst(b_rst), .step_en(b_step_en), .redirect_valid(b_redirect_valid),
    .redirect_pc(b_redirect_pc), .mem_req(b_mem_req), .mem_addr(b_mem_addr),
    .mem_rdata(b_mem_rdata), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_inst(b_out_inst), .out_pc(b_out_pc), .count(b_count)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory models: request seen in cycle N, data driven for the whole of cycle N+1.
  logic        pa_vld = 1'b0, pb_vld = 1'b0;
  logic [31:0] pa_addr = '0, pb_addr = '0;
  always @(negedge clk) begin
    mem_rdata   = pa_vld ? memf(pa_addr) : '0;
    pa_vld      = mem_req;
    pa_addr     = mem_addr;
    b_mem_rdata = pb_vld ? memf(pb_addr) : '0;
    pb_vld      = b_mem_req;
    pb_addr     = b_mem_addr;
  end

  logic [63:0] got[$];
  logic [63:0] got2[$];
  always @(negedge clk) begin
    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) got.push_back({out_pc, out_inst});
    if (b_rst === 1'b1 && b_out_valid === 1'b1 && b_out_ready === 1'b1) got2.push_back({b_out_pc, b_out_inst});
  end

  function automatic logic [63:0] gq(input int i);
    return (i < got.size()) ? got[i] : 64'hx;
  endfunction
  function automatic logic [63:0] gq2(input int i);
    return (i < got2.size()) ? got2[i] : 64'hx;
  endfunction

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic go(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; step_en = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0;
    go();
    rst = 1'b1;
    got.delete();
  endtask

  logic [31:0] e;

  initial begin
    rst = 1'b0; step_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    b_rst = 1'b0; b_step_en = 1'b1; b_redirect_valid = 1'b0; b_redirect_pc = '0; b_out_ready = 1'b1;

    // Reset state
    go(2);
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_out_inst", out_inst, 0);
    chk("rst_out_pc", out_pc, 0);

    // Streaming: one instruction per cycle, first out_valid two cycles after first mem_req
    rst = 1'b1; step_en = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("stream_req%0d", k), mem_req, 1);
      chk($sformatf("stream_addr%0d", k), mem_addr, 32'(4 * k));
      chk($sformatf("stream_valid%0d", k), out_valid, 64'(k >= 2));
      if (k >= 2) begin
        e = 32'(4 * (k - 2));
        chk($sformatf("stream_pc%0d", k), out_pc, e);
        chk($sformatf("stream_inst%0d", k), out_inst, memf(e));
      end
      if (k == 4) chk("stream_count", count, 1);
      go();
    end

    // Backpressure: queue fills with PC 0..12, issue stops, resumes at 16
    do_reset();
    step_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("bp_req%0d", k), mem_req, 64'(k < 4));
      if (k < 4) chk($sformatf("bp_addr%0d", k), mem_addr, 32'(4 * k));
      go();
    end
    #1;
    chk("bp_full_count", count, 4);
    chk("bp_full_req", mem_req, 0);
    chk("bp_full_pc", out_pc, 0);
    out_ready = 1'b1;
    #1;
    chk("bp_drain_req", mem_req, 0);
    go();
    chk("bp_resume_req", mem_req, 1);
    chk("bp_resume_addr", mem_addr, 32'd16);
    go(9);
    chk("bp_got_size", 64'(got.size()), 10);
    for (int i = 0; i < 10; i++) chk($sformatf("bp_got%0d", i), gq(i), {32'(4 * i), memf(32'(4 * i))});

    // Redirect with 3 queued + 1 in flight, coinciding with out_ready
    do_reset();
    step_en = 1'b1;
    go(4);
    chk("rd_pre_count", count, 3);
    chk("rd_pre_valid", out_valid, 1);
    redirect_valid = 1'b1; redirect_pc = 32'h100; out_ready = 1'b1;
    #1;
    chk("rd_cyc_valid", out_valid, 0);
    chk("rd_cyc_req", mem_req, 0);
    go();
    redirect_valid = 1'b0;
    #1;
    chk("rd_r1_count", count, 0);
    chk("rd_r1_req", mem_req, 1);
    chk("rd_r1_addr", mem_addr, 32'h100);
    go();
    chk("rd_r2_addr", mem_addr, 32'h104);
    chk("rd_r2_valid", out_valid, 0);
    go();
    chk("rd_r3_valid", out_valid, 1);
    chk("rd_r3_pc", out_pc, 32'h100);
    chk("rd_r3_inst", out_inst, memf(32'h100));
    go(2);
    chk("rd_got_size", 64'(got.size()), 2);
    chk("rd_got0", gq(0), {32'h100, memf(32'h100)});
    chk("rd_got1", gq(1), {32'h104, memf(32'h104)});

    // step_en pulsed one cycle in five
    do_reset();
    out_ready = 1'b1;
    for (int p = 0; p < 3; p++) begin
      for (int j = 0; j < 5; j++) begin
        step_en = (j == 0);
        #1;
        chk($sformatf("pulse_req%0d_%0d", p, j), mem_req, 64'(j == 0));
        if (j == 0) chk($sformatf("pulse_addr%0d", p), mem_addr, 32'(4 * p));
        go();
      end
    end
    step_en = 1'b0;
    go(3);
    chk("pulse_got_size", 64'(got.size()), 3);
    for (int i = 0; i < 3; i++) chk($sformatf("pulse_got%0d", i), gq(i), {32'(4 * i), memf(32'(4 * i))});

    // Reset for one cycle mid-stream with a read in flight
    do_reset();
    step_en = 1'b1; out_ready = 1'b1;
    go(5);
    rst = 1'b0; step_en = 1'b0;
    go();
    rst = 1'b1;
    got.delete();
    #1;
    chk("mr_count", count, 0);
    chk("mr_valid", out_valid, 0);
    chk("mr_req", mem_req, 0);
    chk("mr_inst", out_inst, 0);
    chk("mr_pc", out_pc, 0);
    go();
    step_en = 1'b1;
    #1;
    chk("mr_restart_req", mem_req, 1);
    chk("mr_restart_addr", mem_addr, 32'h0);
    go(4);
    chk("mr_got_size", 64'(got.size()), 2);
    chk("mr_got0", gq(0), {32'h0, memf(32'h0)});
    chk("mr_got1", gq(1), {32'h4, memf(32'h4)});

    // PC wrap from RESET_PC = FFFF_FFF8
    chk("wrap_rst_count", b_count, 0);
    chk("wrap_rst_valid", b_out_valid, 0);
    b_rst = 1'b1;
    #1;
    chk("wrap_first_addr", b_mem_addr, 32'hFFFF_FFF8);
    go(6);
    chk("wrap_got0", gq2(0), {32'hFFFF_FFF8, memf(32'hFFFF_FFF8)});
    chk("wrap_got1", gq2(1), {32'hFFFF_FFFC, memf(32'hFFFF_FFFC)});
    chk("wrap_got2", gq2(2), {32'h0000_0000, memf(32'h0000_0000)});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
